// File: rtl/fnd_ctrl_watch.sv
// fnd_ctrl_watch: four-digit common-anode 7-segment scan controller for the
// watch datapath. Scans one digit per scan_tick and snapshots the time once
// per frame so a frame never mixes old and new values. The dot on dig2
// blinks at 1 Hz from the centisecond count.
// Optional feature macro: FND_BLINK_EN blanks the field being edited while
// msec >= 50. When undefined, edit_en and field_sel are ignored.
module fnd_ctrl_watch #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  input  logic       disp_sel,
  input  logic       edit_en,
  input  logic [1:0] field_sel,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_data
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] presc;
  logic             scan_tick;
  logic [1:0]       dig;

  logic [6:0] msec_s;
  logic [5:0] sec_s;
  logic [5:0] min_s;
  logic [4:0] hour_s;
  logic       disp_sel_s;

  logic [6:0] v_hi;
  logic [6:0] v_lo;
  logic [7:0] seg_nx;
  logic [3:0] com_nx;
  logic [3:0] com_p1;
  logic [7:0] seg_p1;

  // Segment pattern for one decimal digit, dp off; anything above 9 shows "-".
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hBF;
    endcase
  endfunction

  // Tens (hi=1) or ones (hi=0) digit of a two-digit field value.
  function automatic logic [3:0] digit_val(input logic [6:0] v, input logic hi);
    logic [6:0] q;
    q = hi ? (v / 7'd10) : (v % 7'd10);
    return q[3:0];
  endfunction

  assign scan_tick = (presc == CNT_MAX);

  // Prescaler producing the one-cycle digit-advance pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) presc <= '0;
    else if (scan_tick) presc <= '0;
    else presc <= presc + 1'b1;
  end

  // Digit index advances on every scan tick and wraps 3 -> 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dig <= 2'd0;
    else if (scan_tick) dig <= dig + 2'd1;
  end

  // Frame snapshot, taken on the tick that closes the frame (dig 3 -> 0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msec_s     <= '0;
      sec_s      <= '0;
      min_s      <= '0;
      hour_s     <= '0;
      disp_sel_s <= 1'b0;
    end else if (scan_tick && dig == 2'd3) begin
      msec_s     <= msec;
      sec_s      <= sec;
      min_s      <= min;
      hour_s     <= hour;
      disp_sel_s <= disp_sel;
    end
  end

`ifdef FND_BLINK_EN
  logic       edit_en_s;
  logic [1:0] field_sel_s;
  logic       blank;

  // Edit-mode state is snapshotted with the time so blinking is frame-aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edit_en_s   <= 1'b0;
      field_sel_s <= 2'd3;
    end else if (scan_tick && dig == 2'd3) begin
      edit_en_s   <= edit_en;
      field_sel_s <= field_sel;
    end
  end

  // Blank the edited field's digit pair during the second half of each second.
  always_comb begin
    blank = 1'b0;
    if (edit_en_s && msec_s >= 7'd50) begin
      if (!disp_sel_s && field_sel_s == 2'd0 && dig[1]) blank = 1'b1;
      if (disp_sel_s && field_sel_s == 2'd1 && !dig[1]) blank = 1'b1;
      if (disp_sel_s && field_sel_s == 2'd2 && dig[1])  blank = 1'b1;
    end
  end
`else
  logic unused_edit;
  assign unused_edit = ^{edit_en, field_sel};
`endif

  // Decode the current digit from the snapshot, including dp and blanking.
  always_comb begin
    v_hi   = disp_sel_s ? {2'b00, hour_s} : {1'b0, sec_s};
    v_lo   = disp_sel_s ? {1'b0, min_s} : msec_s;
    seg_nx = 8'hFF;
    case (dig)
      2'd3:    seg_nx = seg7(digit_val(v_hi, 1'b1));
      2'd2:    seg_nx = seg7(digit_val(v_hi, 1'b0));
      2'd1:    seg_nx = seg7(digit_val(v_lo, 1'b1));
      default: seg_nx = seg7(digit_val(v_lo, 1'b0));
    endcase
`ifdef FND_BLINK_EN
    if (blank) seg_nx = 8'hFF;
`endif
    if (dig == 2'd2 && msec_s < 7'd50) seg_nx[7] = 1'b0;
    com_nx = ~(4'b0001 << dig);
  end

  // Registered pin drivers, refreshed on each scan tick; dark during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      com_p1 <= 4'b1111;
      seg_p1 <= 8'hFF;
    end else if (scan_tick) begin
      com_p1 <= com_nx;
      seg_p1 <= seg_nx;
    end
  end

  assign fnd_com  = com_p1;
  assign fnd_data = seg_p1;

endmodule

// File: tb/tb_fnd_ctrl_watch.sv
// tb_fnd_ctrl_watch: directed bench for fnd_ctrl_watch with CLK_HZ=40,
// SCAN_HZ=10 so a new digit is driven every 4 clocks.
module tb_fnd_ctrl_watch;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       disp_sel;
  logic       edit_en;
  logic [1:0] field_sel;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;

  int n_chk  = 0;
  int n_fail = 0;

  fnd_ctrl_watch #(.CLK_HZ(40), .SCAN_HZ(10)) dut (
    .clk(clk), .rst(rst), .msec(msec), .sec(sec), .min(min), .hour(hour),
    .disp_sel(disp_sel), .edit_en(edit_en), .field_sel(field_sel),
    .fnd_com(fnd_com), .fnd_data(fnd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Advance one scan tick (4 clocks) and check both output buses.
  task automatic tick_expect(input string tag, input logic [3:0] com, input logic [7:0] seg);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, ".com"}, {4'h0, fnd_com}, {4'h0, com});
    chk({tag, ".seg"}, fnd_data, seg);
  endtask

  initial begin
    rst = 1'b0; msec = '0; sec = '0; min = '0; hour = '0;
    disp_sel = 1'b0; edit_en = 1'b0; field_sel = 2'd3;

    // Reset: dark outputs
    repeat (3) @(posedge clk);
    #1;
    chk("rst.com", {4'h0, fnd_com}, 8'h0F);
    chk("rst.seg", fnd_data, 8'hFF);

    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_tick.com", {4'h0, fnd_com}, 8'h0F);
    @(posedge clk);
    #1;
    chk("tick1.com", {4'h0, fnd_com}, 8'h0E);
    chk("tick1.seg", fnd_data, 8'hC0);

    // Digit map and dp: hour 23, min 45, msec 10 (latched at end of frame 1)
    disp_sel = 1'b1; hour = 5'd23; min = 6'd45; msec = 7'd10;
    tick_expect("f1.d1", 4'b1101, 8'hC0);
    tick_expect("f1.d2", 4'b1011, 8'h40);
    tick_expect("f1.d3", 4'b0111, 8'hC0);
    tick_expect("map.d0", 4'b1110, 8'h92);
    tick_expect("map.d1", 4'b1101, 8'h99);
    tick_expect("map.d2", 4'b1011, 8'h30);

    // Snapshot: new values must not tear the rest of the current frame
    disp_sel = 1'b0; sec = 6'd12; msec = 7'd34;
    tick_expect("map.d3", 4'b0111, 8'hA4);
    tick_expect("snap.d0", 4'b1110, 8'h99);
    tick_expect("snap.d1", 4'b1101, 8'hB0);
    sec = 6'd13;
    tick_expect("snap.d2_old", 4'b1011, 8'h24);
    tick_expect("snap.d3_old", 4'b0111, 8'hF9);
    tick_expect("snap.d0n", 4'b1110, 8'h99);
    tick_expect("snap.d1n", 4'b1101, 8'hB0);
    tick_expect("snap.d2_new", 4'b1011, 8'h30);

    // Out-of-range msec: tens shows "-", dp off for msec >= 50
    msec = 7'd105;
    tick_expect("snap.d3n", 4'b0111, 8'hF9);
    tick_expect("oor.d0", 4'b1110, 8'h92);
    tick_expect("oor.d1", 4'b1101, 8'hBF);
    tick_expect("oor.d2_dpoff", 4'b1011, 8'hB0);

    // Edit min in hour.min view, msec 70
    edit_en = 1'b1; field_sel = 2'd1; disp_sel = 1'b1; hour = 5'd23; min = 6'd7; msec = 7'd70;
    tick_expect("oor.d3", 4'b0111, 8'hF9);
`ifdef FND_BLINK_EN
    tick_expect("blk70.d0", 4'b1110, 8'hFF);
    tick_expect("blk70.d1", 4'b1101, 8'hFF);
`else
    tick_expect("noblk70.d0", 4'b1110, 8'hF8);
    tick_expect("noblk70.d1", 4'b1101, 8'hC0);
`endif
    tick_expect("blk70.d2", 4'b1011, 8'hB0);
    msec = 7'd20;
    tick_expect("blk70.d3", 4'b0111, 8'hA4);
    tick_expect("blk20.d0", 4'b1110, 8'hF8);
    tick_expect("blk20.d1", 4'b1101, 8'hC0);
    tick_expect("blk20.d2", 4'b1011, 8'h30);

    // Edited field not visible in this view: no blanking
    field_sel = 2'd0; msec = 7'd70;
    tick_expect("blk20.d3", 4'b0111, 8'hA4);
    tick_expect("fs0.d0", 4'b1110, 8'hF8);
    tick_expect("fs0.d1", 4'b1101, 8'hC0);

    // Edit hour: blanks the upper digit pair
    field_sel = 2'd2;
    tick_expect("fs0.d2", 4'b1011, 8'hB0);
    tick_expect("fs0.d3", 4'b0111, 8'hA4);
    tick_expect("fs2.d0", 4'b1110, 8'hF8);
    tick_expect("fs2.d1", 4'b1101, 8'hC0);
`ifdef FND_BLINK_EN
    tick_expect("fs2.d2", 4'b1011, 8'hFF);
    tick_expect("fs2.d3", 4'b0111, 8'hFF);
`else
    tick_expect("fs2.d2", 4'b1011, 8'hB0);
    tick_expect("fs2.d3", 4'b0111, 8'hA4);
`endif

    // Reset mid-frame: immediate dark, restart from dig0 with zero snapshot
    tick_expect("mid.d0", 4'b1110, 8'hF8);
    rst = 1'b0;
    #2;
    chk("midrst.com", {4'h0, fnd_com}, 8'h0F);
    chk("midrst.seg", fnd_data, 8'hFF);
    @(negedge clk) rst = 1'b1;
    tick_expect("restart.d0", 4'b1110, 8'hC0);
    tick_expect("restart.d1", 4'b1101, 8'hC0);
    tick_expect("restart.d2", 4'b1011, 8'h40);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
